// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
//   FETCH_ADDR_W / FETCH_INSTR_W : default PC and instruction widths
//   FETCH_RESET_PC / FETCH_HALT_WORD : reset PC and the word that stops fetching
//   FETCH_DEPTH / FETCH_CNT_W    : instruction buffer depth and occupancy width
//   fetch_state_t                : fetch FSM states
package fetch_pkg;

   localparam int unsigned FETCH_ADDR_W  = 8;
   localparam int unsigned FETCH_INSTR_W = 16;
   localparam int unsigned FETCH_DEPTH   = 2;
   localparam int unsigned FETCH_CNT_W   = 2;

   localparam logic [FETCH_ADDR_W-1:0]  FETCH_RESET_PC  = 8'h00;
   localparam logic [FETCH_INSTR_W-1:0] FETCH_HALT_WORD = 16'h9800;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer holding {pc, instruction} pairs for decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write an entry (ignored when full and not popping)
//   pop        : consume the head (ignored when empty)
//   flush      : discard all entries; wins over push
//   head       : oldest entry, always slot 0
//   valid      : at least one entry held
//   count      : number of entries held (0..2)
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned WIDTH = FETCH_ADDR_W + FETCH_INSTR_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       head,
   output logic                   valid,
   output logic [FETCH_CNT_W-1:0] count
);

   logic [WIDTH-1:0]       slot0;
   logic [WIDTH-1:0]       slot1;
   logic [FETCH_CNT_W-1:0] cnt;
   logic                   do_pop;
   logic                   do_push;

   assign do_pop  = pop & (cnt != '0);
   assign do_push = push & ((cnt != FETCH_CNT_W'(FETCH_DEPTH)) | do_pop);

   // Shift-register organisation: the head is always slot0, so the output
   // comes straight from a flop with no read mux.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0 <= '0;
         slot1 <= '0;
         cnt   <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (do_push && do_pop) begin
         if (cnt == FETCH_CNT_W'(1)) begin
            slot0 <= din;
         end else begin
            slot0 <= slot1;
            slot1 <= din;
         end
      end else if (do_pop) begin
         slot0 <= slot1;
         cnt   <= FETCH_CNT_W'(cnt - FETCH_CNT_W'(1));
      end else if (do_push) begin
         if (cnt == '0) begin
            slot0 <= din;
         end else begin
            slot1 <= din;
         end
         cnt <= FETCH_CNT_W'(cnt + FETCH_CNT_W'(1));
      end
   end

   assign head  = slot0;
   assign valid = (cnt != '0);
   assign count = cnt;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the combinational ROM port from the PC,
// buffers fetched words with their PC and hands them to decode over
// valid/ready. Supports branch redirect and stops after a halt word.
//   clk, rst_n     : clock, asynchronous active-low reset
//   rom_addr       : ROM address (the PC register)
//   rom_data       : ROM word for rom_addr, same cycle
//   redirect_valid : load redirect_pc, flush the buffer, resume fetching
//   redirect_pc    : redirect target
//   instr_valid    : buffer head holds an instruction
//   instr          : head instruction word
//   instr_pc       : address of the head word
//   instr_ready    : decode takes the head this cycle
//   halted         : fetch stopped by the halt word
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned              ADDR_W    = FETCH_ADDR_W,
   parameter int unsigned              INSTR_W   = FETCH_INSTR_W,
   parameter logic [ADDR_W-1:0]        RESET_PC  = FETCH_RESET_PC,
   parameter logic [INSTR_W-1:0]       HALT_WORD = FETCH_HALT_WORD
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [INSTR_W-1:0] rom_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready,
   output logic               halted
);

   localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

   fetch_state_t           state;
   logic [ADDR_W-1:0]      pc;
   logic [FETCH_CNT_W-1:0] count;
   logic [ENTRY_W-1:0]     head;
   logic                   pop;
   logic                   issue;

   assign pop = instr_valid & instr_ready;

   // A slot frees up in the same cycle as a pop, so a full buffer still
   // sustains one fetch per cycle while decode keeps accepting.
   assign issue = (state == RUN) & ~redirect_valid &
                  ((count < FETCH_CNT_W'(FETCH_DEPTH)) | pop);

   // PC and fetch state; halted mirrors the state as its own flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         pc     <= RESET_PC;
         halted <= 1'b0;
      end else if (redirect_valid) begin
         state  <= RUN;
         pc     <= redirect_pc;
         halted <= 1'b0;
      end else if (issue) begin
         pc <= ADDR_W'(pc + ADDR_W'(1));
         if (rom_data == HALT_WORD) begin
            state  <= HALT;
            halted <= 1'b1;
         end
      end
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (issue),
      .pop   (pop),
      .flush (redirect_valid),
      .din   ({pc, rom_data}),
      .head  (head),
      .valid (instr_valid),
      .count (count)
   );

   assign rom_addr = pc;
   assign instr_pc = head[ENTRY_W-1:INSTR_W];
   assign instr    = head[INSTR_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a ROM model answers the fetch port,
// expected {pc, word} pairs are queued per scenario and compared as decode
// accepts them.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        instr_valid;
   logic [15:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_ready;
   logic        halted;

   logic [23:0] sb_q[$];
   logic [23:0] exp_e;
   int          checks;
   int          errors;
   int          cycles;

   instr_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] rom_word(input logic [7:0] a);
      case (a)
         8'h00:   return 16'hC000;
         8'h01:   return 16'hC801;
         8'h02:   return 16'hD002;
         8'h03:   return 16'hD803;
         8'h04:   return 16'hE004;
         8'h05:   return 16'hE805;
         8'h08:   return 16'h2908;
         8'h09:   return 16'h689C;
         8'hFF:   return 16'h9800;
         default: return 16'h0000;
      endcase
   endfunction

   assign rom_data = rom_word(rom_addr);

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: valid=%b halted=%b expected 0 0", instr_valid, halted);
      end
      checks++;
      if (rom_addr !== 8'h00) begin
         errors++;
         $display("FAIL reset_rom_addr: got %h expected 00", rom_addr);
      end
      checks++;
      if (instr !== 16'h0000 || instr_pc !== 8'h00) begin
         errors++;
         $display("FAIL reset_head: got %h/%h expected 00/0000", instr_pc, instr);
      end
      instr_ready = 1'b1;
      rst_n       = 1'b1;
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL release_valid: got %b expected 0", instr_valid);
      end
      sb_q.push_back({8'h00, 16'hC000});
      sb_q.push_back({8'h01, 16'hC801});
      sb_q.push_back({8'h02, 16'hD002});
      @(negedge clk);
      cycles = 0;
      while (sb_q.size() > 0 && cycles < 10) begin
         if (instr_valid && instr_ready) begin
            exp_e = sb_q.pop_front();
            checks++;
            if ({instr_pc, instr} !== exp_e) begin
               errors++;
               $display("FAIL startup_seq: got %h expected %h", {instr_pc, instr}, exp_e);
            end
         end
         cycles++;
         if (sb_q.size() > 0) @(negedge clk);
      end
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL startup_timeout: %0d entries never seen", sb_q.size());
         sb_q.delete();
      end
      checks++;
      if (cycles !== 3) begin
         errors++;
         $display("FAIL startup_rate: took %0d cycles expected 3", cycles);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      instr_ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'h03 || instr !== 16'hD803) begin
         errors++;
         $display("FAIL bp_head: got %b %h/%h expected 1 03/D803", instr_valid, instr_pc, instr);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (rom_addr !== 8'h05) begin
         errors++;
         $display("FAIL bp_rom_addr: got %h expected 05", rom_addr);
      end
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'h03) begin
         errors++;
         $display("FAIL bp_hold: got %b %h expected 1 03", instr_valid, instr_pc);
      end
      instr_ready = 1'b1;
      sb_q.push_back({8'h03, 16'hD803});
      sb_q.push_back({8'h04, 16'hE004});
      sb_q.push_back({8'h05, 16'hE805});
      cycles = 0;
      while (sb_q.size() > 0 && cycles < 10) begin
         if (instr_valid && instr_ready) begin
            exp_e = sb_q.pop_front();
            checks++;
            if ({instr_pc, instr} !== exp_e) begin
               errors++;
               $display("FAIL bp_drain: got %h expected %h", {instr_pc, instr}, exp_e);
            end
         end
         cycles++;
         if (sb_q.size() > 0) @(negedge clk);
      end
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL bp_timeout: %0d entries never seen", sb_q.size());
         sb_q.delete();
      end
      checks++;
      if (cycles !== 3) begin
         errors++;
         $display("FAIL bp_rate: took %0d cycles expected 3", cycles);
      end
   endtask

   task automatic test_redirect_halt();
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 8'hFF;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || rom_addr !== 8'hFF) begin
         errors++;
         $display("FAIL redir_ff: got valid=%b addr=%h expected 0 FF", instr_valid, rom_addr);
      end
      sb_q.push_back({8'hFF, 16'h9800});
      cycles = 0;
      while (sb_q.size() > 0 && cycles < 10) begin
         if (instr_valid && instr_ready) begin
            exp_e = sb_q.pop_front();
            checks++;
            if ({instr_pc, instr} !== exp_e) begin
               errors++;
               $display("FAIL halt_word: got %h expected %h", {instr_pc, instr}, exp_e);
            end
         end
         cycles++;
         if (sb_q.size() > 0) @(negedge clk);
      end
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL halt_timeout: %0d entries never seen", sb_q.size());
         sb_q.delete();
      end
      checks++;
      if (halted !== 1'b1 || rom_addr !== 8'h00) begin
         errors++;
         $display("FAIL halt_set: got halted=%b addr=%h expected 1 00", halted, rom_addr);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || rom_addr !== 8'h00 || halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_frozen: got valid=%b addr=%h halted=%b expected 0 00 1",
                  instr_valid, rom_addr, halted);
      end
   endtask

   task automatic test_halt_redirect();
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 8'h08;
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_before_redir: got %b expected 1", halted);
      end
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++;
      if (halted !== 1'b0 || rom_addr !== 8'h08 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL unhalt: got halted=%b addr=%h valid=%b expected 0 08 0",
                  halted, rom_addr, instr_valid);
      end
      sb_q.push_back({8'h08, 16'h2908});
      sb_q.push_back({8'h09, 16'h689C});
      cycles = 0;
      while (sb_q.size() > 0 && cycles < 10) begin
         if (instr_valid && instr_ready) begin
            exp_e = sb_q.pop_front();
            checks++;
            if ({instr_pc, instr} !== exp_e) begin
               errors++;
               $display("FAIL unhalt_seq: got %h expected %h", {instr_pc, instr}, exp_e);
            end
         end
         cycles++;
         if (sb_q.size() > 0) @(negedge clk);
      end
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL unhalt_timeout: %0d entries never seen", sb_q.size());
         sb_q.delete();
      end
      checks++;
      if (cycles !== 3) begin
         errors++;
         $display("FAIL unhalt_latency: took %0d cycles expected 3", cycles);
      end
   endtask

   task automatic test_redirect_pop();
      @(negedge clk);
      instr_ready    = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 8'h01;
      @(negedge clk);
      redirect_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'h01 || instr !== 16'hC801 || rom_addr !== 8'h03) begin
         errors++;
         $display("FAIL rp_full: got %b %h/%h addr=%h expected 1 01/C801 03",
                  instr_valid, instr_pc, instr, rom_addr);
      end
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 8'h04;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || rom_addr !== 8'h04) begin
         errors++;
         $display("FAIL rp_flush: got valid=%b addr=%h expected 0 04", instr_valid, rom_addr);
      end
      sb_q.push_back({8'h04, 16'hE004});
      cycles = 0;
      while (sb_q.size() > 0 && cycles < 10) begin
         if (instr_valid && instr_ready) begin
            exp_e = sb_q.pop_front();
            checks++;
            if ({instr_pc, instr} !== exp_e) begin
               errors++;
               $display("FAIL rp_target: got %h expected %h", {instr_pc, instr}, exp_e);
            end
         end
         cycles++;
         if (sb_q.size() > 0) @(negedge clk);
      end
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL rp_timeout: %0d entries never seen", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      instr_ready    = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 8'hFF;
      @(negedge clk);
      redirect_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL ar_setup: got halted=%b valid=%b expected 1 1", halted, instr_valid);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || halted !== 1'b0 || rom_addr !== 8'h00) begin
         errors++;
         $display("FAIL ar_clear: got valid=%b halted=%b addr=%h expected 0 0 00",
                  instr_valid, halted, rom_addr);
      end
      #1 rst_n = 1'b1;
      instr_ready = 1'b1;
      sb_q.push_back({8'h00, 16'hC000});
      sb_q.push_back({8'h01, 16'hC801});
      sb_q.push_back({8'h02, 16'hD002});
      @(negedge clk);
      cycles = 0;
      while (sb_q.size() > 0 && cycles < 10) begin
         if (instr_valid && instr_ready) begin
            exp_e = sb_q.pop_front();
            checks++;
            if ({instr_pc, instr} !== exp_e) begin
               errors++;
               $display("FAIL ar_restart: got %h expected %h", {instr_pc, instr}, exp_e);
            end
         end
         cycles++;
         if (sb_q.size() > 0) @(negedge clk);
      end
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL ar_timeout: %0d entries never seen", sb_q.size());
         sb_q.delete();
      end
      checks++;
      if (cycles !== 3) begin
         errors++;
         $display("FAIL ar_rate: took %0d cycles expected 3", cycles);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 8'h00;
      checks         = 0;
      errors         = 0;
      cycles         = 0;
      test_reset();
      test_backpressure();
      test_redirect_halt();
      test_halt_redirect();
      test_redirect_pop();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
